// File: rtl/matdet_seq.sv
// Sequential 2x2 / 3x3 fixed-point determinant built around a single registered multiplier.
// Cofactor expansion along row 0; intermediate overflow is reported through a sticky flag.
module matdet_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int BIN_POS     = 8,
  parameter int MATRIX_SIZE = 3
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             start,
  input  logic [DATA_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0]    a,
  output logic                                             busy,
  output logic                                             done,
  output logic [DATA_WIDTH-1:0]                            det,
  output logic                                             ovf
);

  localparam int W  = DATA_WIDTH;
  localparam int N  = MATRIX_SIZE;
  localparam int AW = W * N * N;
  localparam logic [3:0] LAST = (N == 2) ? 4'd3 : 4'd11;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t state, state_next;
  logic [3:0]   cnt;
  logic [AW-1:0] mat;

  logic signed [W-1:0] e [N*N];
  logic signed [W-1:0] prod, tmp, acc, m0, m1, m2;

  logic signed [W-1:0]   op_x, op_y;
  logic signed [2*W-1:0] full, sh;
  logic                  mul_ovf;

  logic issue, ld_tmp, wr_m0, wr_m1, wr_m2, ld_acc, wr_acc, fin;
  logic add_sel_acc, add_sub;
  logic signed [W-1:0] add_x, add_res;
  logic                add_ovf;

  always_comb begin
    for (int i = 0; i < N * N; i++) e[i] = mat[i*W +: W];
  end

  // Schedule: cnt selects which product to issue and which partial result to fold in.
  generate
    if (N == 2) begin : g_sched2
      always_comb begin
        issue = 1'b0; op_x = '0; op_y = '0;
        ld_tmp = 1'b0; wr_m0 = 1'b0; wr_m1 = 1'b0; wr_m2 = 1'b0;
        ld_acc = 1'b0; wr_acc = 1'b0; fin = 1'b0;
        add_sel_acc = 1'b0; add_sub = 1'b1;
        if (state == MUL) begin
          case (cnt)
            4'd1: begin issue = 1'b1; op_x = e[0]; op_y = e[3]; end
            4'd2: begin issue = 1'b1; op_x = e[1]; op_y = e[2]; ld_tmp = 1'b1; end
            4'd3: fin = 1'b1;
            default: ;
          endcase
        end
      end
    end else begin : g_sched3
      always_comb begin
        issue = 1'b0; op_x = '0; op_y = '0;
        ld_tmp = 1'b0; wr_m0 = 1'b0; wr_m1 = 1'b0; wr_m2 = 1'b0;
        ld_acc = 1'b0; wr_acc = 1'b0; fin = 1'b0;
        add_sel_acc = 1'b0; add_sub = 1'b1;
        if (state == MUL) begin
          case (cnt)
            4'd1:  begin issue = 1'b1; op_x = e[4]; op_y = e[8]; end
            4'd2:  begin issue = 1'b1; op_x = e[5]; op_y = e[7]; ld_tmp = 1'b1; end
            4'd3:  begin issue = 1'b1; op_x = e[3]; op_y = e[8]; wr_m0 = 1'b1; end
            4'd4:  begin issue = 1'b1; op_x = e[5]; op_y = e[6]; ld_tmp = 1'b1; end
            4'd5:  begin issue = 1'b1; op_x = e[3]; op_y = e[7]; wr_m1 = 1'b1; end
            4'd6:  begin issue = 1'b1; op_x = e[4]; op_y = e[6]; ld_tmp = 1'b1; end
            4'd7:  wr_m2 = 1'b1;
            4'd8:  begin issue = 1'b1; op_x = e[0]; op_y = m0; end
            4'd9:  begin issue = 1'b1; op_x = e[1]; op_y = m1; ld_acc = 1'b1; end
            4'd10: begin issue = 1'b1; op_x = e[2]; op_y = m2; wr_acc = 1'b1; add_sel_acc = 1'b1; end
            4'd11: begin fin = 1'b1; add_sel_acc = 1'b1; add_sub = 1'b0; end
            default: ;
          endcase
        end
      end
    end
  endgenerate

  always_comb begin
    full    = op_x * op_y;
    sh      = full >>> BIN_POS;
    mul_ovf = (sh[2*W-1:W-1] != '0) && (sh[2*W-1:W-1] != '1);
  end

  always_comb begin
    add_x   = add_sel_acc ? acc : tmp;
    add_res = add_sub ? (add_x - prod) : (add_x + prod);
    if (add_sub)
      add_ovf = (add_x[W-1] != prod[W-1]) && (add_res[W-1] != add_x[W-1]);
    else
      add_ovf = (add_x[W-1] == prod[W-1]) && (add_res[W-1] != add_x[W-1]);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = MUL;
      MUL:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      mat   <= '0;
      prod  <= '0;
      tmp   <= '0;
      acc   <= '0;
      m0    <= '0;
      m1    <= '0;
      m2    <= '0;
      det   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        mat <= a;
        cnt <= '0;
        ovf <= 1'b0;
      end
      if (state == MUL) cnt <= cnt + 4'd1;
      if (issue) begin
        prod <= sh[W-1:0];
        if (mul_ovf) ovf <= 1'b1;
      end
      if (ld_tmp) tmp <= prod;
      if (ld_acc) acc <= prod;
      if (wr_m0)  m0  <= add_res;
      if (wr_m1)  m1  <= add_res;
      if (wr_m2)  m2  <= add_res;
      if (wr_acc) acc <= add_res;
      if (fin)    det <= add_res;
      if ((wr_m0 || wr_m1 || wr_m2 || wr_acc || fin) && add_ovf) ovf <= 1'b1;
    end
  end

  assign busy = (state == MUL) && (cnt != 4'd0);
  assign done = (state == DONE);

endmodule

// File: tb/tb_matdet_seq.sv
// Scoreboard bench for matdet_seq: one 3x3 and one 2x2 instance, directed vectors,
// expected det/ovf queued at issue and checked by per-instance monitors on done.
module tb_matdet_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start3, start2;
  logic [143:0] a3;
  logic [63:0]  a2;
  logic         busy3, done3, ovf3, busy2, done2, ovf2;
  logic [15:0]  det3, det2;

  typedef struct {
    logic [15:0] det;
    logic        ovf;
  } exp_t;

  exp_t q3[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matdet_seq #(.DATA_WIDTH(16), .BIN_POS(8), .MATRIX_SIZE(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3),
    .busy(busy3), .done(done3), .det(det3), .ovf(ovf3)
  );

  matdet_seq #(.DATA_WIDTH(16), .BIN_POS(8), .MATRIX_SIZE(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2),
    .busy(busy2), .done(done2), .det(det2), .ovf(ovf2)
  );

  localparam logic [15:0] ONE = 16'h0100;

  function automatic logic [143:0] mk3(input logic [15:0] e00, e01, e02,
                                       input logic [15:0] e10, e11, e12,
                                       input logic [15:0] e20, e21, e22);
    return {e22, e21, e20, e12, e11, e10, e02, e01, e00};
  endfunction

  function automatic logic [63:0] mk2(input logic [15:0] e00, e01, e10, e11);
    return {e11, e10, e01, e00};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitors: every done pops one expected result
  always @(negedge clk) begin
    if (done3) begin
      checkOutput("u3_done_expected", q3.size() != 0, 1);
      checkOutput("u3_busy_with_done", busy3, 0);
      if (q3.size() != 0) begin
        exp_t x;
        x = q3.pop_front();
        checkOutput("u3_det", det3, x.det);
        checkOutput("u3_ovf", ovf3, x.ovf);
      end
    end
    if (done2) begin
      checkOutput("u2_done_expected", q2.size() != 0, 1);
      if (q2.size() != 0) begin
        exp_t x;
        x = q2.pop_front();
        checkOutput("u2_det", det2, x.det);
        checkOutput("u2_ovf", ovf2, x.ovf);
      end
    end
  end

  task automatic applyStimulus(input int size, input logic [143:0] m3, input logic [63:0] m2,
                               input logic [15:0] exp_det, input logic exp_ovf,
                               input bit repulse, input bit scramble);
    int  k;
    bit  seen;
    bit  busy_ok;
    int  lat;
    lat = (size == 2) ? 4 : 12;
    @(negedge clk);
    if (size == 2) begin
      a2 = m2; start2 = 1'b1; q2.push_back('{exp_det, exp_ovf});
    end else begin
      a3 = m3; start3 = 1'b1; q3.push_back('{exp_det, exp_ovf});
    end
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    start3 = 1'b0;
    if (scramble) a3 = ~m3;
    checkOutput("busy_low_after_accept", (size == 2) ? busy2 : busy3, 0);
    k = 0; seen = 0; busy_ok = 1;
    while (k < 30 && !seen) begin
      @(posedge clk);
      k++;
      #1;
      start3 = (repulse && k == 2);
      if ((size == 2) ? done2 : done3) seen = 1;
      else if (((size == 2) ? busy2 : busy3) !== 1'b1) busy_ok = 0;
    end
    checkOutput("done_latency", k, lat);
    checkOutput("busy_until_done", busy_ok, 1);
    @(posedge clk);
    #1;
    checkOutput("done_single_pulse", (size == 2) ? done2 : done3, 0);
    if (repulse) repeat (16) @(posedge clk);
  endtask

  initial begin
    logic [143:0] id3, m_a, m_b, big3;
    logic [143:0] seq[3];
    logic [15:0]  seq_det[3];
    int k, nd, last, ndone;

    id3  = mk3(ONE, 0, 0, 0, ONE, 0, 0, 0, ONE);
    m_a  = mk3(16'h0200, 0, ONE, ONE, 16'h0300, 16'h0200, ONE, ONE, 16'h0200);
    m_b  = mk3(ONE, 16'h0300, 16'h0200, 16'h0200, 0, ONE, ONE, ONE, 16'h0200);
    big3 = mk3(16'h1000, 0, 0, 0, 16'h1000, 0, 0, 0, 16'h1000);

    rst = 1'b1; start3 = 1'b0; start2 = 1'b0; a3 = '0; a2 = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy3, 0);
    checkOutput("reset_done", done3, 0);
    checkOutput("reset_det", det3, 0);
    checkOutput("reset_ovf", ovf3, 0);
    checkOutput("reset_det2", det2, 0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(3, id3, '0, 16'h0100, 1'b0, 0, 0);
    applyStimulus(3, m_a, '0, 16'h0600, 1'b0, 0, 0);
    applyStimulus(3, m_b, '0, 16'hFA00, 1'b0, 0, 0);
    applyStimulus(3, m_a, '0, 16'h0600, 1'b0, 0, 1);
    applyStimulus(3, big3, '0, 16'h0000, 1'b1, 0, 0);
    applyStimulus(3, m_b, '0, 16'hFA00, 1'b0, 1, 0);
    applyStimulus(3, id3, '0, 16'h0100, 1'b0, 0, 0);

    applyStimulus(2, '0, mk2(16'h0180, 16'h0080, 16'h0040, 16'h0200), 16'h02E0, 1'b0, 0, 0);
    applyStimulus(2, '0, mk2(16'h6400, 0, 0, 16'h6400), 16'h1000, 1'b1, 0, 0);
    applyStimulus(2, '0, mk2(ONE, 0, 0, ONE), 16'h0100, 1'b0, 0, 0);
    applyStimulus(2, '0, mk2(16'hFF00, 16'h0200, 16'h0300, 16'h0400), 16'hF600, 1'b0, 0, 0);

    // Abort mid-operation: no result may appear afterwards
    @(negedge clk);
    a3 = m_a; start3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start3 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("abort_busy", busy3, 0);
    checkOutput("abort_det", det3, 0);
    checkOutput("abort_ovf", ovf3, 0);
    ndone = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done3) ndone++;
    end
    checkOutput("abort_no_done", ndone, 0);

    // Reset and start together: reset wins
    @(negedge clk);
    rst = 1'b1; start3 = 1'b1; a3 = id3;
    @(negedge clk);
    rst = 1'b0; start3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_start_busy", busy3, 0);

    // Back-to-back with start held high, new matrix loaded after each done
    seq[0] = m_a; seq[1] = m_b; seq[2] = id3;
    seq_det[0] = 16'h0600; seq_det[1] = 16'hFA00; seq_det[2] = 16'h0100;
    for (int i = 0; i < 3; i++) q3.push_back('{seq_det[i], 1'b0});
    @(negedge clk);
    a3 = seq[0]; start3 = 1'b1;
    nd = 0; k = 0; last = 0;
    while (nd < 3 && k < 80) begin
      @(posedge clk);
      k++;
      #1;
      if (done3) begin
        nd++;
        if (nd > 1) checkOutput("b2b_period", k - last, 14);
        last = k;
        if (nd < 3) a3 = seq[nd];
        else start3 = 1'b0;
      end
    end
    start3 = 1'b0;
    checkOutput("b2b_count", nd, 3);
    repeat (4) @(posedge clk);

    checkOutput("q3_drained", q3.size(), 0);
    checkOutput("q2_drained", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
